// File: rtl/modn_pkg.sv
// Shared types and default sizing for the mod-N ripple counter checker.
package modn_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'b00,
        TRACK   = 2'b01,
        FAULT   = 2'b10
    } state_t;

    localparam int DEF_W      = 3;
    localparam int DEF_N      = 5;
    localparam int DEF_WRAP_W = 16;
    localparam int DEF_STABLE = 2;

endpackage

// File: rtl/sync_stable_filter.sv
// Two-flop synchroniser for the rippling count bus followed by a run-length filter
// that flags the cycle on which a synced value has been seen STABLE times in a row.
module sync_stable_filter #(
    parameter int W      = 3,
    parameter int STABLE = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] raw,
    output logic [W-1:0] value,
    output logic         hit
);

    localparam int RUN_W = $clog2(STABLE + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE);

    logic [W-1:0]     sync1;
    logic [W-1:0]     sync2;
    logic [W-1:0]     cand;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_next;
    logic             same;

    // The run saturates at STABLE so a held value produces exactly one hit.
    always_comb begin
        same  = (sync2 == cand);
        value = sync2;
        if (!same) begin
            run_next = RUN_W'(1);
        end else if (run == RUN_MAX) begin
            run_next = run;
        end else begin
            run_next = run + RUN_W'(1);
        end
        hit = (run_next == RUN_MAX) && !(same && (run == RUN_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            run   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            cand  <= sync2;
            run   <= run_next;
        end
    end

endmodule

// File: rtl/modn_count_checker.sv
// Monitors a ripple mod-N counter: deglitches its count onto clk, checks each
// accepted step for legality, counts wraps and latches sticky fault flags.
module modn_count_checker
    import modn_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int N      = DEF_N,
    parameter int WRAP_W = DEF_WRAP_W,
    parameter int STABLE = DEF_STABLE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [W-1:0]      cnt_in,
    input  logic              clr_err,
    output logic [W-1:0]      cnt_q,
    output logic              cnt_valid,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              err_illegal,
    output logic              err_skip,
    output logic [1:0]        state_o
);

    localparam int WX = W + 1;
    localparam logic [WX-1:0] N_EXT    = WX'(N);
    localparam logic [WX-1:0] LAST_EXT = WX'(N - 1);

    state_t              state;
    state_t              state_next;
    logic [W-1:0]        value;
    logic                hit;
    logic                acc;
    logic                first_acq;
    logic                first_next;
    logic [W-1:0]        cnt_next;
    logic                pulse_next;
    logic                ill_next;
    logic                skip_next;
    logic [WRAP_W-1:0]   wc_next;
    logic [WX-1:0]       value_ext;
    logic [WX-1:0]       prev_inc;

    sync_stable_filter #(
        .W      (W),
        .STABLE (STABLE)
    ) u_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (cnt_in),
        .value (value),
        .hit   (hit)
    );

    // Widened compare values keep prev+1 from aliasing to 0 when N == 2**W.
    assign value_ext = {1'b0, value};
    assign prev_inc  = {1'b0, cnt_q} + WX'(1);
    assign acc       = hit && ((value != cnt_q) || first_acq);

    always_comb begin
        state_next = state;
        cnt_next   = cnt_q;
        pulse_next = 1'b0;
        ill_next   = err_illegal;
        skip_next  = err_skip;
        wc_next    = wrap_count;
        first_next = first_acq;
        if (en) begin
            case (state)
                ACQUIRE: begin
                    if (acc) begin
                        cnt_next   = value;
                        first_next = 1'b0;
                        if (value_ext < N_EXT) begin
                            state_next = TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (acc) begin
                        cnt_next   = value;
                        first_next = 1'b0;
                        if (value_ext >= N_EXT) begin
                            ill_next   = 1'b1;
                            state_next = FAULT;
                        end else if (value_ext == prev_inc) begin
                            state_next = TRACK;
                        end else if (({1'b0, cnt_q} == LAST_EXT) && (value == '0)) begin
                            pulse_next = 1'b1;
                            if (wrap_count != '1) begin
                                wc_next = wrap_count + WRAP_W'(1);
                            end
                        end else begin
                            skip_next  = 1'b1;
                            state_next = FAULT;
                        end
                    end
                end
                FAULT: begin
                    // A clear drops any same-cycle acceptance; ACQUIRE waits for a fresh one.
                    if (clr_err) begin
                        ill_next   = 1'b0;
                        skip_next  = 1'b0;
                        wc_next    = '0;
                        first_next = 1'b1;
                        state_next = ACQUIRE;
                    end else if (acc) begin
                        cnt_next = value;
                    end
                end
                default: begin
                    state_next = ACQUIRE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACQUIRE;
            cnt_q       <= '0;
            cnt_valid   <= 1'b0;
            wrap_pulse  <= 1'b0;
            wrap_count  <= '0;
            err_illegal <= 1'b0;
            err_skip    <= 1'b0;
            first_acq   <= 1'b1;
        end else begin
            state       <= state_next;
            cnt_q       <= cnt_next;
            cnt_valid   <= (state_next == TRACK);
            wrap_pulse  <= pulse_next;
            wrap_count  <= wc_next;
            err_illegal <= ill_next;
            err_skip    <= skip_next;
            first_acq   <= first_next;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_modn_count_checker.sv
// Scoreboard bench for modn_count_checker: each driven step queues the expected
// output word and the edge it should appear on; a negedge monitor pops and compares.
module tb_modn_count_checker;

    localparam logic [1:0] S_ACQ   = 2'b00;
    localparam logic [1:0] S_TRACK = 2'b01;
    localparam logic [1:0] S_FAULT = 2'b10;
    localparam logic [12:0] PULSE_BIT = 13'h0200;

    typedef struct {
        int          edge_no;
        logic [12:0] val;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [2:0]  cnt_in = 3'd0;
    logic        clr_err = 1'b0;
    logic [2:0]  cnt_q;
    logic        cnt_valid;
    logic        wrap_pulse;
    logic [3:0]  wrap_count;
    logic        err_illegal;
    logic        err_skip;
    logic [1:0]  state_o;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic [12:0] prev_snap = 13'h0;
    logic [12:0] cur;
    exp_t        e;

    modn_count_checker #(
        .W      (3),
        .N      (5),
        .WRAP_W (4),
        .STABLE (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cnt_in      (cnt_in),
        .clr_err     (clr_err),
        .cnt_q       (cnt_q),
        .cnt_valid   (cnt_valid),
        .wrap_pulse  (wrap_pulse),
        .wrap_count  (wrap_count),
        .err_illegal (err_illegal),
        .err_skip    (err_skip),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [12:0] packOut();
        return {cnt_valid, err_illegal, err_skip, wrap_pulse, state_o, wrap_count, cnt_q};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pushExpect(input string tag, input int delay, input logic [2:0] c,
                              input logic [1:0] st, input logic p, input logic [3:0] wc,
                              input logic ill, input logic skip);
        exp_t x;
        x.edge_no = cyc + delay;
        x.val     = {(st == S_TRACK), ill, skip, p, st, wc, c};
        x.tag     = tag;
        sb.push_back(x);
    endtask

    task automatic applyStimulus(input logic [2:0] v, input int hold);
        cnt_in = v;
        repeat (hold) @(negedge clk);
    endtask

    task automatic resetDut(input string tag);
        mon_en  = 1'b0;
        rst_n   = 1'b0;
        cnt_in  = 3'd0;
        en      = 1'b1;
        clr_err = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        checkOutput({tag, "_reset"}, 32'(packOut()), 32'h0);
        rst_n     = 1'b1;
        prev_snap = 13'h0;
        pushExpect({tag, "_acq"}, 2, 3'd0, S_TRACK, 1'b0, 4'd0, 1'b0, 1'b0);
        mon_en = 1'b1;
    endtask

    task automatic checkDrain(input string tag);
        checkOutput({tag, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    // Any output change (or a wrap pulse) must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            cur = packOut();
            if (((cur & ~PULSE_BIT) != prev_snap) || wrap_pulse) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_event", 32'(cur), 32'(prev_snap));
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.tag, "_edge"}, 32'(cyc), 32'(e.edge_no));
                    checkOutput({e.tag, "_out"}, 32'(cur), 32'(e.val));
                end
            end
            prev_snap = cur & ~PULSE_BIT;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetDut("t1");
        applyStimulus(3'd0, 6);
        for (int v = 1; v <= 4; v++) begin
            pushExpect("t1_step", 4, 3'(v), S_TRACK, 1'b0, 4'd0, 1'b0, 1'b0);
            applyStimulus(3'(v), 6);
        end
        pushExpect("t1_wrap", 4, 3'd0, S_TRACK, 1'b1, 4'd1, 1'b0, 1'b0);
        applyStimulus(3'd0, 6);
        pushExpect("t1_after", 4, 3'd1, S_TRACK, 1'b0, 4'd1, 1'b0, 1'b0);
        applyStimulus(3'd1, 6);
        checkDrain("t1");

        pushExpect("t2_two", 4, 3'd2, S_TRACK, 1'b0, 4'd1, 1'b0, 1'b0);
        applyStimulus(3'd2, 6);
        applyStimulus(3'd6, 1);
        pushExpect("t2_three", 4, 3'd3, S_TRACK, 1'b0, 4'd1, 1'b0, 1'b0);
        applyStimulus(3'd3, 6);
        checkDrain("t2");

        pushExpect("t3_four", 4, 3'd4, S_TRACK, 1'b0, 4'd1, 1'b0, 1'b0);
        applyStimulus(3'd4, 6);
        pushExpect("t3_wrap", 4, 3'd0, S_TRACK, 1'b1, 4'd2, 1'b0, 1'b0);
        applyStimulus(3'd0, 6);
        pushExpect("t3_one", 4, 3'd1, S_TRACK, 1'b0, 4'd2, 1'b0, 1'b0);
        applyStimulus(3'd1, 6);
        pushExpect("t3_skip", 4, 3'd3, S_FAULT, 1'b0, 4'd2, 1'b0, 1'b1);
        applyStimulus(3'd3, 6);
        pushExpect("t3_clear", 1, 3'd3, S_ACQ, 1'b0, 4'd0, 1'b0, 1'b0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        repeat (5) @(negedge clk);
        pushExpect("t3_reacq", 4, 3'd2, S_TRACK, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(3'd2, 6);
        checkDrain("t3");

        pushExpect("t4_illegal", 4, 3'd7, S_FAULT, 1'b0, 4'd0, 1'b1, 1'b0);
        applyStimulus(3'd7, 6);
        cnt_in = 3'd4;
        repeat (3) @(negedge clk);
        pushExpect("t4_clr_acc", 1, 3'd7, S_ACQ, 1'b0, 4'd0, 1'b0, 1'b0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        repeat (8) @(negedge clk);
        pushExpect("t4_reacq", 4, 3'd0, S_TRACK, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(3'd0, 6);
        checkDrain("t4");

        for (int w = 1; w <= 16; w++) begin
            for (int v = 1; v <= 4; v++) begin
                pushExpect("t5_step", 4, 3'(v), S_TRACK, 1'b0, 4'(w - 1), 1'b0, 1'b0);
                applyStimulus(3'(v), 6);
            end
            pushExpect("t5_wrap", 4, 3'd0, S_TRACK, 1'b1, (w >= 15) ? 4'd15 : 4'(w), 1'b0, 1'b0);
            applyStimulus(3'd0, 6);
        end
        checkDrain("t5");
        checkOutput("t5_sat", 32'(wrap_count), 32'd15);

        pushExpect("mid_step", 4, 3'd1, S_TRACK, 1'b0, 4'd15, 1'b0, 1'b0);
        cnt_in = 3'd1;
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst", 32'(packOut()), 32'h0);

        resetDut("t6");
        applyStimulus(3'd0, 6);
        pushExpect("t6_one", 4, 3'd1, S_TRACK, 1'b0, 4'd0, 1'b0, 1'b0);
        applyStimulus(3'd1, 6);
        en = 1'b0;
        applyStimulus(3'd2, 8);
        checkOutput("t6_hold", 32'(cnt_q), 32'd1);
        en = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("t6_still", 32'(cnt_q), 32'd1);
        pushExpect("t6_skip", 4, 3'd3, S_FAULT, 1'b0, 4'd0, 1'b0, 1'b1);
        applyStimulus(3'd3, 6);
        checkDrain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
